// File: rtl/alu_pkg.sv
// Shared operation encoding and FSM state type for the sequential ALU.
// op[2] selects the inverted B operand, matching the original 1-bit ALU slice.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: one partial product per run cycle.
// done is asserted combinationally during the last step; product then holds the final value.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CNT_W'(WIDTH - 1));

  // NOTE: the operand/accumulator registers are reset too, so an aborted multiply leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with registered, handshaked outputs and a multi-cycle unsigned multiply.
// Single-cycle ops complete in one cycle; MUL occupies the block for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   b_eff, sum, dp_result;
  logic               carry_in, carry_out, carry_msb, add_ovf;
  logic               dp_cout, dp_ovf;
  logic               accept, is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // A new operand set may enter only when the output register is free or being drained.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    b_eff     = op[2] ? ~b : b;
    carry_in  = (op == OP_ADD) ? cin : op[2];
    {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    carry_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    add_ovf   = carry_msb ^ carry_out;
    dp_result = '0;
    dp_cout   = 1'b0;
    dp_ovf    = 1'b0;
    case (op[1:0])
      2'b00: dp_result = a & b_eff;
      2'b01: dp_result = a | b_eff;
      2'b10: begin
        dp_result = sum;
        dp_cout   = carry_out;
        dp_ovf    = add_ovf;
      end
      default: begin
        if (op[2]) begin
          dp_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
          dp_cout   = carry_out;
          dp_ovf    = add_ovf;
        end
      end
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .run     (state_q == ST_MUL),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_done)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= dp_result;
      cout      <= dp_cout;
      overflow  <= dp_ovf;
      zero      <= (dp_result == '0);
    end else if (accept) begin
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product[WIDTH-1:0];
      cout      <= |mul_product[2*WIDTH-1:WIDTH];
      overflow  <= 1'b0;
      zero      <= (mul_product[WIDTH-1:0] == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: a reference model predicts each accepted op,
// a monitor compares every output transfer in order.
module tb_alu_seq;

  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       cout;
  logic       overflow;
  logic       zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic mc, input logic [2:0] mop);
    exp_t e;
    int ua, ub, sa, sbv, full, sres;
    ua  = int'(ma);
    ub  = int'(mb);
    sa  = int'($signed(ma));
    sbv = int'($signed(mb));
    e   = '0;
    case (mop)
      OP_AND:  e.r = ma & mb;
      OP_OR:   e.r = ma | mb;
      OP_ANDN: e.r = ma & ~mb;
      OP_ORN:  e.r = ma | ~mb;
      OP_ADD: begin
        full = ua + ub + int'(mc);
        sres = sa + sbv + int'(mc);
        e.r  = full[7:0];
        e.c  = (full > 255);
        e.v  = (sres > 127) || (sres < -128);
      end
      OP_SUB, OP_SLT: begin
        full = ua + (255 - ub) + 1;
        sres = sa - sbv;
        e.c  = (full > 255);
        e.v  = (sres > 127) || (sres < -128);
        e.r  = (mop == OP_SUB) ? full[7:0] : ((sa < sbv) ? 8'd1 : 8'd0);
      end
      default: begin
        full = ua * ub;
        e.r  = full[7:0];
        e.c  = (full > 255);
      end
    endcase
    e.z = (e.r == 8'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got result=%h cout=%b ovf=%b zero=%b", result, cout, overflow, zero);
      end else begin
        mon_e = sb.pop_front();
        if ({result, cout, overflow, zero} !== {mon_e.r, mon_e.c, mon_e.v, mon_e.z}) begin
          errors++;
          $display("FAIL output got result=%h cout=%b ovf=%b zero=%b expected result=%h cout=%b ovf=%b zero=%b",
                   result, cout, overflow, zero, mon_e.r, mon_e.c, mon_e.v, mon_e.z);
        end
      end
    end
  end

  // Entered and left at posedge+1; holds in_valid until the DUT accepts.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic [2:0] iop);
    int n;
    n = 0;
    a = ia; b = ib; cin = ic; op = iop; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got in_ready=0 expected 1 within 100 cycles");
    end else begin
      sb.push_back(model(ia, ib, ic, iop));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; op = OP_AND;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, result, cout, overflow, zero, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h c=%b o=%b z=%b rdy=%b expected v=0 r=00 c=0 o=0 z=0 rdy=1",
               out_valid, result, cout, overflow, zero, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    issue(8'd3, 8'd5, 1'b0, OP_MUL);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_mul cycle %0d got v=%b r=%h rdy=%b expected v=0 r=00 rdy=1",
                 i, out_valid, result, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_logic();
    issue(8'hFF, 8'h01, 1'b0, OP_ADD);
    issue(8'hFF, 8'h01, 1'b1, OP_ADD);
    issue(8'h7F, 8'h01, 1'b0, OP_ADD);
    issue(8'h80, 8'h01, 1'b0, OP_SLT);
    issue(8'h01, 8'h80, 1'b0, OP_SLT);
    issue(8'h05, 8'h05, 1'b1, OP_SUB);
    issue(8'h80, 8'h01, 1'b0, OP_SUB);
    issue(8'hF0, 8'h3C, 1'b1, OP_ANDN);
    issue(8'hF0, 8'h3C, 1'b0, OP_ORN);
    issue(8'hF0, 8'h3C, 1'b0, OP_AND);
    issue(8'hF0, 8'h0C, 1'b0, OP_OR);
    drain();
  endtask

  task automatic test_mul();
    issue(8'h10, 8'h11, 1'b0, OP_MUL);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (i < 9 && (in_ready !== 1'b0 || out_valid !== 1'b0)) begin
        errors++;
        $display("FAIL mul_busy cycle %0d got rdy=%b v=%b expected rdy=0 v=0", i, in_ready, out_valid);
      end else if (i == 9 && out_valid !== 1'b1) begin
        errors++;
        $display("FAIL mul_latency cycle 9 got out_valid=%b expected 1", out_valid);
      end
    end
    @(posedge clk);
    #1;
    issue(8'd12, 8'd10, 1'b0, OP_MUL);
    issue(8'hFF, 8'hFF, 1'b0, OP_MUL);
    issue(8'h00, 8'h9A, 1'b0, OP_MUL);
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    out_ready = 1'b0;
    issue(8'd1, 8'd2, 1'b0, OP_ADD);
    a = 8'h55; b = 8'hAA; op = OP_OR; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 8'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d got v=%b r=%h rdy=%b expected v=1 r=03 rdy=0",
                 i, out_valid, result, in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    t0 = cyc;
    issue(8'd10, 8'd20, 1'b0, OP_ADD);
    issue(8'd30, 8'd40, 1'b1, OP_ADD);
    issue(8'd50, 8'd60, 1'b0, OP_ADD);
    issue(8'd70, 8'd80, 1'b1, OP_ADD);
    checks++;
    if (cyc - t0 !== 4) begin
      errors++;
      $display("FAIL throughput got %0d cycles for 4 ops expected 4", cyc - t0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    drain();
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_add_logic();
    test_mul();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU; successor to the 1-bit ALU slice, same 3-bit op encoding (op[2] = b-invert).
- Adds a multi-cycle unsigned multiply and registered outputs with valid/ready handshakes on input and output.
- Sits between the operand-fetch stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand/result width (>=2).
- CNT_W, $clog2(WIDTH)+1, multiply step-counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, ADD only.
- op  in  3  operation select.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- result  out  WIDTH  result.
- cout  out  1  carry-out / unsigned multiply overflow.
- overflow  out  1  signed overflow (ADD/SUB).
- zero  out  1  result == 0.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, result=0, cout=0, overflow=0, zero=0, step counter=0.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 ADD (a+b+cin)
  - 011 MUL
  - 100 a&~b
  - 101 a|~b
  - 110 SUB (a+~b+1; cin ignored)
  - 111 SLT
- SLT: result = {WIDTH-1 zeros, sign(a-b) XOR overflow(a-b)}; cout/overflow are those of the internal subtraction.
- Logic ops: cout=0, overflow=0.
- ADD/SUB: cout = carry out of bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB.
- MUL: unsigned; result = low WIDTH bits of a*b; cout = OR of high WIDTH product bits; overflow=0.
- zero is always computed from the registered result.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready.
    - On accept with a non-MUL op: result/flags registered; out_valid=1 next cycle (latency 1). Back-to-back accepts give full throughput.
    - On accept with MUL: latch a, b; clear accumulator; counter=0; go to MUL. out_valid drops to 0 if the pending result was consumed that cycle.
  - MUL: in_ready=0. One shift-add step per cycle on b's LSB. After WIDTH steps go to IDLE with out_valid=1. Latency from accept to out_valid = WIDTH+1 cycles.
- Output hold: while out_valid && !out_ready, result and flags stay stable and in_ready=0.
- out_valid clears on output transfer unless a new accept happens in the same cycle; in that case the new result is loaded and out_valid stays 1.
- Changes to a/b/op while in MUL have no effect.
- in_valid with in_ready=0: no state change; the producer must hold its inputs.
- Reset asserted mid-MUL aborts the operation; no output is produced.
- Counter: no wrap beyond WIDTH; the transition out of MUL happens exactly when counter == WIDTH-1.

Decomposition:
- Package alu_pkg:
  - op localparams OP_AND, OP_OR, OP_ADD, OP_MUL, OP_ANDN, OP_ORN, OP_SUB, OP_SLT.
  - state encoding ST_IDLE, ST_MUL.
- Sub-module alu_mul_seq: shift-add multiplier with start/done, WIDTH parameter, 2*WIDTH accumulator, CNT_W counter.
- The combinational single-cycle datapath stays inline in alu_seq.

Test Plan (WIDTH=8):
- Reset mid-MUL: accept MUL a=3 b=5, assert rst on cycle 3 -> out_valid=0, result=0, in_ready=1 after release; no result emitted.
- ADD carry: a=0xFF b=0x01 cin=0 op=010 -> next cycle result=0x00, cout=1, zero=1, overflow=0. Same with cin=1 -> result=0x01, cout=1.
- Signed overflow/SLT: a=0x7F b=0x01 op=010 -> result=0x80, overflow=1. Then a=0x80 b=0x01 op=111 -> result=0x01 (−128<1), overflow=1.
- b-invert logic: a=0xF0 b=0x3C op=100 -> result=0xC0; op=101 -> result=0xF3; cout=overflow=0.
- MUL latency/overflow: a=0x10 b=0x11 op=011 -> in_ready=0 for 8 cycles, out_valid at cycle 9, result=0x10, cout=1. a=12 b=10 -> result=0x78, cout=0.
- Backpressure/throughput: out_ready=0, issue ADD 1+2 -> result=3 held and in_ready=0 for 4 cycles. Then out_ready=1 with a continuous stream of 4 ADDs -> one result per cycle, in order, none dropped.
